// File: rtl/cam_handoff_ring.sv
// Ring of NCAM camera buffers: one camera films at a time, hands filming to its
// successor near full, then holds its data until downloaded or flushed.
module cam_handoff_ring #(
    parameter  int NCAM      = 2,
    parameter  int DEPTH     = 100,
    parameter  int STBY_PCT  = 80,
    parameter  int FILM_PCT  = 90,
    parameter  int FLUSH_PCT = 50,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 start,
    input  logic [NCAM-1:0]      download,
    output logic [3*NCAM-1:0]    cam_state,
    output logic [CW*NCAM-1:0]   fill,
    output logic [NCAM-1:0]      ready_to_download,
    output logic [2:0]           active_idx,
    output logic [NCAM-1:0]      overflow
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STANDBY = 3'd1,
        ST_FILM    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DRAIN   = 3'd4
    } cam_st_e;

    localparam int T_STBY_I  = (DEPTH * STBY_PCT) / 100;
    localparam int T_FILM_I  = (DEPTH * FILM_PCT) / 100;
    localparam int T_FLUSH_I = (DEPTH * FLUSH_PCT) / 100;

    localparam logic [CW-1:0] T_STBY  = CW'(T_STBY_I);
    localparam logic [CW-1:0] T_FILM  = CW'(T_FILM_I);
    localparam logic [CW-1:0] T_FLUSH = CW'(T_FLUSH_I);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    if (NCAM < 2 || NCAM > 8) begin : g_bad_ncam
        $error("cam_handoff_ring: NCAM must be in 2..8");
    end
    if (!(T_FLUSH_I < T_STBY_I && T_STBY_I < T_FILM_I && T_FILM_I <= DEPTH)) begin : g_bad_thr
        $error("cam_handoff_ring: thresholds must satisfy T_FLUSH < T_STBY < T_FILM <= DEPTH");
    end

    function automatic int succ(input int i);
        return (i + 1) % NCAM;
    endfunction

    function automatic int pred(input int i);
        return (i + NCAM - 1) % NCAM;
    endfunction

    cam_st_e         state_q [NCAM];
    cam_st_e         state_d [NCAM];
    logic [CW-1:0]   fill_q  [NCAM];
    logic [CW-1:0]   fill_d  [NCAM];
    logic [NCAM-1:0] ovf_q, ovf_d;

    logic [NCAM-1:0] handoff;
    logic [NCAM-1:0] stby_req;
    logic            all_idle;

    // A successor that is itself filming (the NCAM=2 wrap) is busy, so it never
    // qualifies as a handoff target.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        all_idle = 1'b1;
        handoff  = '0;
        stby_req = '0;
        for (int i = 0; i < NCAM; i++) begin
            if (state_q[i] != ST_IDLE) all_idle = 1'b0;
            handoff[i]  = (state_q[i] == ST_FILM) && (fill_q[i] >= T_FILM) &&
                          ((state_q[succ(i)] == ST_IDLE) || (state_q[succ(i)] == ST_STANDBY));
            stby_req[i] = (state_q[i] == ST_FILM) && (fill_q[i] >= T_STBY) &&
                          (state_q[succ(i)] == ST_IDLE);
        end
    end

    always_comb begin
        for (int i = 0; i < NCAM; i++) begin
            state_d[i] = state_q[i];
            fill_d[i]  = fill_q[i];
            ovf_d[i]   = ovf_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (i == 0 && start && all_idle) state_d[i] = ST_FILM;
                    else if (handoff[pred(i)])        state_d[i] = ST_FILM;
                    else if (stby_req[pred(i)])       state_d[i] = ST_STANDBY;
                end
                ST_STANDBY: begin
                    if (handoff[pred(i)]) state_d[i] = ST_FILM;
                end
                ST_FILM: begin
                    if (handoff[i]) begin
                        state_d[i] = ST_HOLD;
                    end else begin
                        if (tick && fill_q[i] != FULL) fill_d[i] = fill_q[i] + ONE;
                        if (fill_d[i] == FULL) ovf_d[i] = 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Download beats flush when both are possible.
                    if (download[i]) begin
                        state_d[i] = ST_DRAIN;
                    end else if (fill_q[succ(i)] >= T_FLUSH) begin
                        state_d[i] = ST_IDLE;
                        fill_d[i]  = '0;
                    end
                end
                ST_DRAIN: begin
                    if (fill_q[i] == '0) begin
                        state_d[i] = ST_IDLE;
                    end else if (tick) begin
                        fill_d[i] = fill_q[i] - ONE;
                        if (fill_q[i] == ONE) state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    fill_d[i]  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCAM; i++) begin
                state_q[i] <= ST_IDLE;
                fill_q[i]  <= '0;
            end
            ovf_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            for (int i = 0; i < NCAM; i++) begin
                state_q[i] <= state_d[i];
                fill_q[i]  <= fill_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        active_idx = 3'd7;
        for (int i = 0; i < NCAM; i++) begin
            cam_state[3*i +: 3]   = state_q[i];
            fill[CW*i +: CW]      = fill_q[i];
            ready_to_download[i]  = (state_q[i] == ST_HOLD);
            if (state_q[i] == ST_FILM) active_idx = 3'(i);
        end
    end

    assign overflow = ovf_q;

endmodule

// File: tb/tb_cam_handoff_ring.sv
// Directed bench for cam_handoff_ring with NCAM=2, DEPTH=10
// (T_STBY=8, T_FILM=9, T_FLUSH=5).
module tb_cam_handoff_ring;

    localparam int NCAM = 2;
    localparam int DEPTH = 10;
    localparam int CW = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              tick;
    logic              start;
    logic [NCAM-1:0]   download;
    logic [3*NCAM-1:0] cam_state;
    logic [CW*NCAM-1:0] fill;
    logic [NCAM-1:0]   ready_to_download;
    logic [2:0]        active_idx;
    logic [NCAM-1:0]   overflow;

    int n_asserts = 0;
    int n_fails   = 0;

    cam_handoff_ring #(
        .NCAM(NCAM), .DEPTH(DEPTH), .STBY_PCT(80), .FILM_PCT(90), .FLUSH_PCT(50)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .tick              (tick),
        .start             (start),
        .download          (download),
        .cam_state         (cam_state),
        .fill              (fill),
        .ready_to_download (ready_to_download),
        .active_idx        (active_idx),
        .overflow          (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [2:0] st(input int i);
        return cam_state[3*i +: 3];
    endfunction

    function automatic logic [CW-1:0] fl(input int i);
        return fill[CW*i +: CW];
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_state"},    32'(cam_state), 32'h0);
        check({tag, "_fill"},     32'(fill), 32'h0);
        check({tag, "_overflow"}, 32'(overflow), 32'h0);
        check({tag, "_rdy"},      32'(ready_to_download), 32'h0);
        check({tag, "_active"},   32'(active_idx), 32'd7);
    endtask

    initial begin
        reset_n  = 1'b0;
        tick     = 1'b1;
        start    = 1'b0;
        download = '0;
        #3;
        check_reset_state("reset");
        #9 reset_n = 1'b1;

        // Stays idle without start.
        step(3);
        check("idle_wait_state", 32'(cam_state), 32'h0);
        check("idle_wait_active", 32'(active_idx), 32'd7);

        // Start: camera 0 films.
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_st0", 32'(st(0)), 32'd2);
        check("start_active", 32'(active_idx), 32'd0);
        check("start_fl0", 32'(fl(0)), 32'd0);

        // download[1] while camera 1 idle is ignored.
        download = 2'b10;
        step(1);
        download = '0;
        check("dl_ignored_st1", 32'(st(1)), 32'd0);
        check("fill_1", 32'(fl(0)), 32'd1);

        step(7);
        check("fill_8", 32'(fl(0)), 32'd8);
        check("no_stby_yet", 32'(st(1)), 32'd0);
        step(1);
        check("fill_9", 32'(fl(0)), 32'd9);
        check("standby_st1", 32'(st(1)), 32'd1);

        // Handoff 0 -> 1.
        step(1);
        check("ho1_state", 32'(cam_state), 32'({3'd2, 3'd3}));
        check("ho1_active", 32'(active_idx), 32'd1);
        check("ho1_rdy", 32'(ready_to_download), 32'b01);
        check("ho1_fl0", 32'(fl(0)), 32'd9);
        check("ho1_fl1", 32'(fl(1)), 32'd0);

        // Flush of undownloaded camera 0 when camera 1 reaches 5.
        step(5);
        check("pre_flush_fl1", 32'(fl(1)), 32'd5);
        check("pre_flush_st0", 32'(st(0)), 32'd3);
        step(1);
        check("flush_st0", 32'(st(0)), 32'd0);
        check("flush_fl0", 32'(fl(0)), 32'd0);
        check("flush_rdy", 32'(ready_to_download), 32'b00);

        // start ignored while a camera is busy.
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_ignored_st0", 32'(st(0)), 32'd0);
        check("start_ignored_active", 32'(active_idx), 32'd1);
        check("start_ignored_fl1", 32'(fl(1)), 32'd7);

        step(2);
        check("stby0_fl1", 32'(fl(1)), 32'd9);
        check("stby0_st0", 32'(st(0)), 32'd1);

        // Handoff 1 -> 0 (wrap).
        step(1);
        check("ho2_state", 32'(cam_state), 32'({3'd3, 3'd2}));
        check("ho2_active", 32'(active_idx), 32'd0);
        check("ho2_rdy", 32'(ready_to_download), 32'b10);

        // Download on the exact cycle the flush condition appears.
        step(5);
        check("race_fl0", 32'(fl(0)), 32'd5);
        download = 2'b10;
        step(1);
        download = '0;
        check("race_st1_drain", 32'(st(1)), 32'd4);
        check("race_fl1_kept", 32'(fl(1)), 32'd9);
        check("race_fl0", 32'(fl(0)), 32'd6);

        // Camera 0 blocked by draining camera 1: saturates and flags overflow.
        step(4);
        check("ovf_fl0", 32'(fl(0)), 32'd10);
        check("ovf_flag", 32'(overflow), 32'b01);
        check("ovf_st0", 32'(st(0)), 32'd2);
        check("ovf_st1_still_drain", 32'(st(1)), 32'd4);
        check("ovf_fl1", 32'(fl(1)), 32'd5);
        step(4);
        check("drain_fl1_1", 32'(fl(1)), 32'd1);
        check("drain_fl0_sat", 32'(fl(0)), 32'd10);
        step(1);
        check("drain_done_st1", 32'(st(1)), 32'd0);
        check("drain_done_fl1", 32'(fl(1)), 32'd0);
        check("blocked_st0", 32'(st(0)), 32'd2);

        // Blocked handoff completes once camera 1 is idle.
        step(1);
        check("ho3_state", 32'(cam_state), 32'({3'd2, 3'd3}));
        check("ho3_active", 32'(active_idx), 32'd1);
        check("ho3_fl0", 32'(fl(0)), 32'd10);
        check("ovf_sticky", 32'(overflow), 32'b01);

        // tick=0 freezes fills; download still evaluated.
        tick = 1'b0;
        step(3);
        check("tick0_fl1", 32'(fl(1)), 32'd0);
        check("tick0_state", 32'(cam_state), 32'({3'd2, 3'd3}));
        download = 2'b01;
        step(1);
        download = '0;
        check("tick0_dl_st0", 32'(st(0)), 32'd4);
        check("tick0_dl_fl0", 32'(fl(0)), 32'd10);
        tick = 1'b1;
        step(4);
        check("drain_fl0_6", 32'(fl(0)), 32'd6);
        check("film_fl1_4", 32'(fl(1)), 32'd4);

        // Asynchronous reset mid-period during DRAIN.
        #3 reset_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        #2 reset_n = 1'b1;
        step(2);
        check("post_reset_state", 32'(cam_state), 32'h0);
        check("post_reset_fill", 32'(fill), 32'h0);
        check("post_reset_active", 32'(active_idx), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
